// File: rtl/core_loader.sv
// Boot loader: turns a framed byte stream into instruction-memory writes, then releases the core.
// Optional register preload section is built only when CORE_LOADER_REGLOAD_EN is defined.
module core_loader #(
   parameter int IMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte_data,
   output logic        o_byte_ready,
   output logic [31:0] o_inst_mem_addr,
   output logic [31:0] o_inst_mem_data,
   output logic        o_inst_mem_we,
   output logic [4:0]  o_load_reg_addr,
   output logic [31:0] o_load_reg_data,
   output logic        o_load_reg_we,
   output logic        o_setup,
   output logic [31:0] o_pc_instr_start_addr,
   output logic        o_done,
   output logic        o_err
);
   // state   | meaning
   // IDLE    | hunting for sync byte 0xA5
   // HDR     | collecting start address (4 B) and word count (2 B)
   // WORD    | assembling instruction words, one strobe per word
   // REGS    | register preload records (optional build)
   // RELEASE | single cycle before the core leaves setup mode
   // DONE    | load complete, terminal until reset
   // ERR     | bad header, terminal until reset
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_WORD,
`ifdef CORE_LOADER_REGLOAD_EN
      S_REGS,
`endif
      S_RELEASE,
      S_DONE,
      S_ERR
   } state_t;

`ifdef CORE_LOADER_REGLOAD_EN
   localparam state_t S_AFTER_WORDS = S_REGS;
`else
   localparam state_t S_AFTER_WORDS = S_RELEASE;
`endif
   localparam logic [31:0] IMEM_MAX = IMEM_WORDS;

   state_t      state, state_nxt;
   logic [2:0]  byte_cnt;
   logic [31:0] shift;
   logic [7:0]  n_lo;
   logic [15:0] n_words;
   logic [15:0] word_cnt;
   logic [31:0] addr_nxt;
   logic        reg_busy;
   logic        take;
   logic        hdr_last;
   logic [15:0] hdr_n;

   assign take     = i_byte_valid && o_byte_ready;
   assign hdr_last = (state == S_HDR) && take && (byte_cnt == 3'd5);
   assign hdr_n    = {i_byte_data, n_lo};

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

`ifdef CORE_LOADER_REGLOAD_EN
   logic        have_cnt;
   logic [7:0]  reg_m;
   logic [7:0]  reg_cnt;
   logic [2:0]  rb_cnt;
   logic [4:0]  ra_buf;
   logic [31:0] rshift;
   logic        take_regs;
   logic        regs_end;

   assign take_regs = take && (state == S_REGS);
   assign regs_end  = (take_regs && !have_cnt && (i_byte_data == 8'd0)) ||
                      (o_load_reg_we && (reg_cnt == reg_m));
   assign reg_busy  = o_load_reg_we;

   // First byte of the section is the record count; each record is addr + 4 data bytes.
   always_ff @(posedge clk) begin
      if (rst) begin
         have_cnt        <= 1'b0;
         reg_m           <= 8'd0;
         reg_cnt         <= 8'd0;
         rb_cnt          <= 3'd0;
         ra_buf          <= 5'd0;
         rshift          <= 32'd0;
         o_load_reg_we   <= 1'b0;
         o_load_reg_addr <= 5'd0;
         o_load_reg_data <= 32'd0;
      end else begin
         o_load_reg_we <= 1'b0;
         if (take_regs) begin
            if (!have_cnt) begin
               have_cnt <= 1'b1;
               reg_m    <= i_byte_data;
            end else begin
               rb_cnt <= rb_cnt + 3'd1;
               if (rb_cnt == 3'd0) ra_buf <= i_byte_data[4:0];
               else                rshift <= {i_byte_data, rshift[31:8]};
               if (rb_cnt == 3'd4) begin
                  rb_cnt          <= 3'd0;
                  o_load_reg_we   <= 1'b1;
                  o_load_reg_addr <= ra_buf;
                  o_load_reg_data <= {i_byte_data, rshift[31:8]};
                  reg_cnt         <= reg_cnt + 8'd1;
               end
            end
         end
      end
   end
`else
   assign reg_busy        = 1'b0;
   assign o_load_reg_we   = 1'b0;
   assign o_load_reg_addr = 5'd0;
   assign o_load_reg_data = 32'd0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (take && (i_byte_data == 8'hA5)) state_nxt = S_HDR;
         S_HDR: begin
            if (hdr_last) begin
               if ((shift[1:0] != 2'b00) || ({16'd0, hdr_n} > IMEM_MAX)) state_nxt = S_ERR;
               else if (hdr_n == 16'd0)                                   state_nxt = S_AFTER_WORDS;
               else                                                       state_nxt = S_WORD;
            end
         end
         // Leave on the strobe cycle of the last word so RELEASE follows it.
         S_WORD: if (o_inst_mem_we && (word_cnt == n_words)) state_nxt = S_AFTER_WORDS;
`ifdef CORE_LOADER_REGLOAD_EN
         S_REGS: if (regs_end) state_nxt = S_RELEASE;
`endif
         S_RELEASE: state_nxt = S_DONE;
         default:   state_nxt = state;
      endcase
   end

   always_comb begin
      o_byte_ready = 1'b0;
      case (state)
         S_IDLE, S_HDR, S_WORD: o_byte_ready = !o_inst_mem_we && !reg_busy;
`ifdef CORE_LOADER_REGLOAD_EN
         S_REGS:                o_byte_ready = !o_inst_mem_we && !reg_busy;
`endif
         default:               o_byte_ready = 1'b0;
      endcase
      o_setup = (state != S_DONE);
      o_done  = (state == S_DONE);
      o_err   = (state == S_ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt              <= 3'd0;
         shift                 <= 32'd0;
         n_lo                  <= 8'd0;
         n_words               <= 16'd0;
         word_cnt              <= 16'd0;
         addr_nxt              <= 32'd0;
         o_inst_mem_we         <= 1'b0;
         o_inst_mem_addr       <= 32'd0;
         o_inst_mem_data       <= 32'd0;
         o_pc_instr_start_addr <= 32'd0;
      end else begin
         o_inst_mem_we <= 1'b0;
         if (take) begin
            case (state)
               S_HDR: begin
                  byte_cnt <= byte_cnt + 3'd1;
                  if (byte_cnt < 3'd4)       shift <= {i_byte_data, shift[31:8]};
                  else if (byte_cnt == 3'd4) n_lo  <= i_byte_data;
                  else begin
                     byte_cnt              <= 3'd0;
                     n_words               <= hdr_n;
                     o_pc_instr_start_addr <= shift;
                     addr_nxt              <= shift;
                  end
               end
               S_WORD: begin
                  byte_cnt <= byte_cnt + 3'd1;
                  shift    <= {i_byte_data, shift[31:8]};
                  if (byte_cnt == 3'd3) begin
                     byte_cnt        <= 3'd0;
                     o_inst_mem_we   <= 1'b1;
                     o_inst_mem_addr <= addr_nxt;
                     o_inst_mem_data <= {i_byte_data, shift[31:8]};
                     addr_nxt        <= addr_nxt + 32'd4;
                     word_cnt        <= word_cnt + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_core_loader.sv
// Bench for core_loader: directed and random frames with random valid gaps, checked against a frame-level model.
module tb_core_loader;
   localparam int IMEM = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_byte_valid = 1'b0;
   logic [7:0]  i_byte_data = 8'd0;
   logic        o_byte_ready;
   logic [31:0] o_inst_mem_addr, o_inst_mem_data;
   logic        o_inst_mem_we;
   logic [4:0]  o_load_reg_addr;
   logic [31:0] o_load_reg_data;
   logic        o_load_reg_we;
   logic        o_setup;
   logic [31:0] o_pc_instr_start_addr;
   logic        o_done, o_err;

   core_loader #(.IMEM_WORDS(IMEM)) dut (
      .clk(clk), .rst(rst), .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data),
      .o_byte_ready(o_byte_ready), .o_inst_mem_addr(o_inst_mem_addr),
      .o_inst_mem_data(o_inst_mem_data), .o_inst_mem_we(o_inst_mem_we),
      .o_load_reg_addr(o_load_reg_addr), .o_load_reg_data(o_load_reg_data),
      .o_load_reg_we(o_load_reg_we), .o_setup(o_setup),
      .o_pc_instr_start_addr(o_pc_instr_start_addr), .o_done(o_done), .o_err(o_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_we_cyc = -1;
   int fall_cyc = -1;
   bit prev_setup = 1'b1;
   logic [63:0] wq[$];
   logic [31:0] words_q[$];
   logic [7:0]  junk_q[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (o_inst_mem_we) begin
         wq.push_back({o_inst_mem_addr, o_inst_mem_data});
         last_we_cyc = cyc;
      end
      if (prev_setup && !o_setup) fall_cyc = cyc;
      prev_setup = o_setup;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      i_byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wq.delete();
      last_we_cyc = -1;
      fall_cyc = -1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      bit sent = 1'b0;
      while (!sent && guard < 200) begin
         @(negedge clk);
         guard++;
         if ($urandom_range(0, 3) == 0) begin
            i_byte_valid = 1'b0;
            i_byte_data  = 8'($urandom);
         end else begin
            i_byte_valid = 1'b1;
            i_byte_data  = b;
            if (o_byte_ready) sent = 1'b1;
         end
      end
      check("byte_accept", 32'(sent), 32'd1);
   endtask

   // Model: a header is rejected for a misaligned start or too many words; otherwise
   // word k lands at start+4k and the core is released two cycles after the last strobe.
   task automatic run_frame(input string tag, input bit with_reset, input logic [31:0] start, input int n);
      logic [7:0] fq[$];
      bit exp_err;
      int t;
      if (with_reset) do_reset();
      exp_err = (start[1:0] != 2'b00) || (n > IMEM);
      foreach (junk_q[i]) fq.push_back(junk_q[i]);
      fq.push_back(8'hA5);
      for (int i = 0; i < 4; i++) fq.push_back(8'(start >> (8 * i)));
      fq.push_back(8'(n));
      fq.push_back(8'(n >> 8));
      if (!exp_err)
         for (int k = 0; k < n; k++)
            for (int i = 0; i < 4; i++) fq.push_back(8'(words_q[k] >> (8 * i)));
      foreach (fq[i]) send_byte(fq[i]);
      @(negedge clk);
      i_byte_valid = 1'b0;
      t = 0;
      while (!(o_done || o_err) && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      check({tag, "_done"}, 32'(o_done), 32'(!exp_err));
      check({tag, "_err"}, 32'(o_err), 32'(exp_err));
      check({tag, "_setup"}, 32'(o_setup), 32'(exp_err));
      check({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
      check({tag, "_nwr"}, wq.size(), exp_err ? 0 : n);
      if (!exp_err) begin
         check({tag, "_pc"}, o_pc_instr_start_addr, start);
         for (int k = 0; k < n && k < wq.size(); k++) begin
            check({tag, "_addr"}, wq[k][63:32], start + 32'(4 * k));
            check({tag, "_data"}, wq[k][31:0], words_q[k]);
         end
         if (n > 0) check({tag, "_rel_lat"}, fall_cyc - last_we_cyc, 2);
      end
      check({tag, "_regwe"}, {26'd0, o_load_reg_we, o_load_reg_addr}, 32'd0);
   endtask

   initial begin
      logic [31:0] st;
      int n;
      // Reset state
      do_reset();
      check("rst_setup", 32'(o_setup), 32'd1);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);
      check("rst_we", 32'(o_inst_mem_we), 32'd0);
      check("rst_addr", o_inst_mem_addr, 32'd0);
      check("rst_data", o_inst_mem_data, 32'd0);
      check("rst_pc", o_pc_instr_start_addr, 32'd0);
      check("rst_ready", 32'(o_byte_ready), 32'd1);
      check("rst_regdata", o_load_reg_data, 32'd0);

      // Reference two-word frame, then with leading junk
      words_q = '{32'h00127413, 32'h006208B3};
      run_frame("ref", 1'b1, 32'h4, 2);
      junk_q = '{8'h00, 8'hFF};
      run_frame("junk", 1'b1, 32'h4, 2);
      junk_q.delete();

      // Header errors and limits
      run_frame("misalign", 1'b1, 32'h6, 2);
      run_frame("toomany", 1'b1, 32'h100, 257);
      run_frame("zero", 1'b1, 32'h40, 0);
      run_frame("wrap", 1'b1, 32'hFFFF_FFFC, 2);
      words_q.delete();
      for (int k = 0; k < IMEM; k++) words_q.push_back($urandom);
      run_frame("full", 1'b1, 32'h1000, IMEM);

      // Reset mid-word discards the partial word; a resent frame loads normally
      do_reset();
      words_q = '{32'h00127413, 32'h006208B3};
      send_byte(8'hA5);
      send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h74);
      @(negedge clk);
      i_byte_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_nwr", wq.size(), 0);
      check("midrst_setup", 32'(o_setup), 32'd1);
      check("midrst_ready", 32'(o_byte_ready), 32'd1);
      run_frame("resend", 1'b0, 32'h4, 2);

      // Random frames
      for (int it = 0; it < 8; it++) begin
         st = $urandom;
         st[1:0] = ($urandom_range(0, 3) == 0) ? 2'(1 + $urandom_range(0, 2)) : 2'b00;
         case ($urandom_range(0, 4))
            0:       n = 0;
            1:       n = 257 + $urandom_range(0, 50);
            default: n = 1 + $urandom_range(0, 5);
         endcase
         junk_q.delete();
         for (int j = 0; j < $urandom_range(0, 3); j++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            junk_q.push_back(b);
         end
         words_q.delete();
         for (int k = 0; k < n && k < IMEM; k++) words_q.push_back($urandom);
         run_frame("rand", 1'b1, st, n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/core_loader.md
CORE_LOADER -- requirements
Module: core_loader

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 256, the instruction-memory capacity in 32-bit words; a header count above it is an error.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_byte_valid  input  1  byte-stream valid.
REQ-005 SHALL have port i_byte_data  input  8  byte-stream payload.
REQ-006 SHALL have port o_byte_ready  output  1  loader can accept a byte; a byte transfers on a cycle with i_byte_valid=1 and o_byte_ready=1.
REQ-007 SHALL have ports o_inst_mem_addr (32), o_inst_mem_data (32) and o_inst_mem_we (1), all outputs, forming the instruction-memory write port into the core.
REQ-008 SHALL have ports o_load_reg_addr (5), o_load_reg_data (32) and o_load_reg_we (1), all outputs, forming the register-file preload port (present only under REQ-027).
REQ-009 SHALL have port o_setup  output  1  holds the core in setup mode while 1.
REQ-010 SHALL have port o_pc_instr_start_addr  output  32  first PC handed to the core.
REQ-011 SHALL have ports o_done (1) and o_err (1), both outputs, giving load complete and load failed status.

Function
REQ-012 SHALL accept this frame format, all multi-byte fields little-endian: sync 0xA5, start address (4 B), word count N (2 B), then N instruction words (4 B each).
REQ-013 SHALL use FSM states IDLE, HDR, WORD, REGS (under REQ-027 only), RELEASE, DONE and ERR.
REQ-014 In IDLE, SHALL discard bytes other than 0xA5 and move to HDR on 0xA5.
REQ-015 In HDR, after 6 accepted bytes: start[1:0]!=0 or N>IMEM_WORDS -> ERR; N=0 -> REGS or RELEASE; otherwise -> WORD.
REQ-016 In WORD, SHALL assemble 4 bytes per word; on the cycle after the 4th byte is accepted, o_inst_mem_we=1 for exactly one cycle, with o_inst_mem_addr=start+4*k (k=0..N-1, 32-bit wrap) and o_inst_mem_data set to the assembled word.
REQ-017 After word N-1 is written, SHALL go to REGS or RELEASE.
REQ-018 RELEASE SHALL last one cycle; on the next edge it SHALL set o_setup=0 and o_done=1, and enter DONE.
REQ-019 o_pc_instr_start_addr SHALL be registered when HDR completes and held stable until reset.
REQ-020 o_byte_ready SHALL be 1 in IDLE, HDR, WORD and REGS, and 0 in RELEASE, DONE and ERR; no byte is accepted on a cycle where a write strobe is being issued, so at most one strobe is in flight.
REQ-021 DONE and ERR SHALL be terminal until rst. In ERR: o_err=1, o_setup stays 1, and no further writes occur.
REQ-022 Write strobes SHALL be single-cycle and mutually exclusive; addr/data SHALL hold their last values when the strobe is 0.
REQ-023 Gaps in i_byte_valid at any point SHALL stall the FSM without losing the partial byte count.

Reset
REQ-024 On rst=1, SHALL set: state=IDLE, o_setup=1, o_done=0, o_err=0, all *_we=0, all addr/data outputs=0, o_pc_instr_start_addr=0, byte and word counters=0.
REQ-025 rst asserted mid-frame SHALL discard any partial word with no write on the reset cycle; the stream restarts from sync.
REQ-026 rst SHALL take priority over a simultaneous byte transfer.

Configuration
REQ-027 With macro CORE_LOADER_REGLOAD_EN defined, SHALL include the REGS section after the words: count M (1 B), then M records of reg addr (1 B, bits[4:0] used) plus data (4 B LE).
REQ-028 Under REQ-027, each completed record SHALL pulse o_load_reg_we for one cycle; M=0 goes straight to RELEASE.
REQ-029 Without CORE_LOADER_REGLOAD_EN, the REGS state and register logic SHALL be absent, and o_load_reg_we/addr/data SHALL be tied 0.

Verification
REQ-030 Frame A5 04 00 00 00 02 00 13 74 12 00 B3 08 62 00 -> two writes: (0x4, 0x00127413) then (0x8, 0x006208B3); o_setup falls 2 cycles after the 2nd strobe; o_pc_instr_start_addr=0x4; o_done=1.
REQ-031 Bytes 00 FF then the frame of REQ-030 -> the leading bytes are ignored and the result is identical to REQ-030.
REQ-032 Start address 0x00000006 -> o_err=1, o_setup=1, no write strobes, o_byte_ready=0.
REQ-033 Header with N=257 and IMEM_WORDS=256 -> ERR; with N=0 -> o_done with no instruction writes.
REQ-034 rst for 1 cycle after the 2nd byte of word 0 -> no strobe; a full frame resent afterwards loads correctly.
REQ-035 Under CORE_LOADER_REGLOAD_EN, N=0 followed by 01 04 01 00 00 00 -> one o_load_reg_we with addr 4, data 0x00000001, then done.
